// File: rtl/periph_bridge.sv
// periph_bridge: decodes CPU load/store accesses onto the 8-bit peripheral
// bus (one-hot slot select, 5-bit offset, single-cycle strobes) and returns
// a zero-extended read word with a one-cycle ready pulse. Unmapped slots and
// silent peripherals complete with bus_err so the CPU is never stalled.
module periph_bridge #(
  parameter int          NUM_PERIPH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int          TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               cpu_addr,
  input  logic                      cpu_rd_en,
  input  logic                      cpu_wr_en,
  input  logic [31:0]               cpu_wr_data,
  output logic [31:0]               cpu_rd_data,
  output logic                      cpu_ready,
  output logic                      bus_err,
  output logic [NUM_PERIPH-1:0]     p_sel,
  output logic [4:0]                p_addr,
  output logic                      p_rd_en,
  output logic                      p_wr_en,
  output logic [7:0]                p_wr_data,
  input  logic [8*NUM_PERIPH-1:0]   p_rd_data,
  input  logic [NUM_PERIPH-1:0]     p_rd_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_DONE} state_t;

  localparam logic [3:0] NP_L = 4'(NUM_PERIPH);
  localparam logic [7:0] TO_L = 8'(TIMEOUT);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [31:0]             rd_data_q, rd_data_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [NUM_PERIPH-1:0]   sel_q, sel_d;
  logic [4:0]              addr_q, addr_d;
  logic                    rd_en_q, rd_en_d;
  logic                    wr_en_q, wr_en_d;
  logic [7:0]              wr_data_q, wr_data_d;

  logic [2:0]              slot;
  logic                    hit;
  logic                    sel_vld;
  logic [7:0]              sel_dat;
  logic                    unused_wr_hi;

  // Only the low byte of write data reaches the 8-bit bus.
  assign unused_wr_hi = ^cpu_wr_data[31:8];

  assign slot = cpu_addr[7:5];
  assign hit  = (cpu_addr[31:8] == BASE_ADDR[31:8]) && ({1'b0, slot} < NP_L);

  // Pick the read response of the currently selected slot; others are ignored.
  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      if (sel_q[k]) begin
        sel_vld = sel_vld | p_rd_valid[k];
        sel_dat = sel_dat | p_rd_data[8*k +: 8];
      end
    end
  end

  // Next-state and next-output logic; strobes default low, read data holds.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    sel_d     = '0;
    addr_d    = '0;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cpu_wr_en || cpu_rd_en) begin
          if (!hit) begin
            state_d   = S_DONE;
            ready_d   = 1'b1;
            err_d     = 1'b1;
            rd_data_d = '0;
          end else begin
            for (int k = 0; k < NUM_PERIPH; k++) sel_d[k] = (slot == 3'(k));
            addr_d = cpu_addr[4:0];
            if (cpu_wr_en) begin
              // A simultaneous read request is dropped in favour of the write.
              state_d   = S_DONE;
              wr_en_d   = 1'b1;
              wr_data_d = cpu_wr_data[7:0];
              ready_d   = 1'b1;
              rd_data_d = '0;
            end else begin
              state_d = S_RD_WAIT;
              rd_en_d = 1'b1;
            end
          end
        end
      end
      S_RD_WAIT: begin
        sel_d  = sel_q;
        addr_d = addr_q;
        // A valid in the same cycle as the timeout still wins.
        if (sel_vld) begin
          state_d   = S_DONE;
          ready_d   = 1'b1;
          rd_data_d = {24'h0, sel_dat};
          sel_d     = '0;
          addr_d    = '0;
        end else if (cnt_q == TO_L) begin
          state_d   = S_DONE;
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rd_data_d = 32'hFFFF_FFFF;
          sel_d     = '0;
          addr_d    = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign cpu_rd_data = rd_data_q;
  assign cpu_ready   = ready_q;
  assign bus_err     = err_q;
  assign p_sel       = sel_q;
  assign p_addr      = addr_q;
  assign p_rd_en     = rd_en_q;
  assign p_wr_en     = wr_en_q;
  assign p_wr_data   = wr_data_q;

endmodule

// File: tb/tb_periph_bridge.sv
// tb_periph_bridge: randomized transactions against a transaction-level
// reference model of the bridge (latency, error and data per access).
module tb_periph_bridge;

  localparam int          NP   = 4;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int          TO   = 15;
  localparam int          NEVER = 999;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         cpu_addr;
  logic                cpu_rd_en;
  logic                cpu_wr_en;
  logic [31:0]         cpu_wr_data;
  logic [31:0]         cpu_rd_data;
  logic                cpu_ready;
  logic                bus_err;
  logic [NP-1:0]       p_sel;
  logic [4:0]          p_addr;
  logic                p_rd_en;
  logic                p_wr_en;
  logic [7:0]          p_wr_data;
  logic [8*NP-1:0]     p_rd_data;
  logic [NP-1:0]       p_rd_valid;

  int n_chk  = 0;
  int n_fail = 0;

  periph_bridge #(.NUM_PERIPH(NP), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .cpu_ready(cpu_ready), .bus_err(bus_err),
    .p_sel(p_sel), .p_addr(p_addr), .p_rd_en(p_rd_en), .p_wr_en(p_wr_en),
    .p_wr_data(p_wr_data), .p_rd_data(p_rd_data), .p_rd_valid(p_rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Peripheral side: slot 'own' answers only when 'give'; all other slots
  // chatter with random valids and data that the bridge must ignore.
  task automatic drive_rsp(input int own, input logic give, input logic [7:0] d);
    for (int k = 0; k < NP; k++) begin
      if (k == own) begin
        p_rd_valid[k]       = give;
        p_rd_data[8*k +: 8] = give ? d : 8'($urandom);
      end else begin
        p_rd_valid[k]       = 1'($urandom_range(0, 1));
        p_rd_data[8*k +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(cpu_ready), 32'd0);
    chk({tag, "_err"},   32'(bus_err),   32'd0);
    chk({tag, "_rdata"}, cpu_rd_data,    32'd0);
    chk({tag, "_strb"},  32'({p_rd_en, p_wr_en}), 32'd0);
    chk({tag, "_sel"},   32'(p_sel),     32'd0);
    chk({tag, "_bus"},   32'({p_addr, p_wr_data}), 32'd0);
  endtask

  // One CPU access. 'lat' is the number of cycles after the p_rd_en cycle
  // at which the addressed peripheral raises rd_valid (NEVER = silent).
  task automatic txn(input logic [31:0] addr, input logic rd, input logic wr,
                     input logic [31:0] wdat, input int lat, input logic [7:0] rdat);
    int          slot, exp_c, nrd, nwr, own;
    logic        hit, is_rd, exp_err, seen;
    logic [31:0] exp_dat;
    logic [NP-1:0] oh;
    slot  = int'(addr[7:5]);
    hit   = (addr[31:8] == BASE[31:8]) && (slot < NP);
    is_rd = rd && !wr;
    oh    = '0;
    if (hit) oh[slot] = 1'b1;
    if (!hit || !is_rd) begin
      exp_c   = 1;
      exp_err = !hit;
      exp_dat = 32'd0;
    end else begin
      exp_c   = 2 + ((lat < TO) ? lat : TO);
      exp_err = (lat > TO);
      exp_dat = exp_err ? 32'hFFFF_FFFF : {24'h0, rdat};
    end
    nrd = 0; nwr = 0; seen = 1'b0;
    @(negedge clk);
    cpu_addr = addr; cpu_rd_en = rd; cpu_wr_en = wr; cpu_wr_data = wdat;
    drive_rsp(-1, 1'b0, 8'h00);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (p_wr_en) begin
        nwr++;
        chk("wr_strobe_cycle", 32'(c), 32'd1);
        chk("wr_sel", 32'(p_sel), 32'(oh));
        chk("wr_addr", 32'(p_addr), 32'(addr[4:0]));
        chk("wr_data", 32'(p_wr_data), 32'(wdat[7:0]));
      end
      if (p_rd_en) begin
        nrd++;
        chk("rd_strobe_cycle", 32'(c), 32'd1);
      end
      if (c == 1 && !hit) chk("miss_no_sel", 32'(p_sel), 32'd0);
      if (hit && is_rd && c < exp_c) begin
        chk("rdwait_sel", 32'(p_sel), 32'(oh));
        chk("rdwait_addr", 32'(p_addr), 32'(addr[4:0]));
      end
      if (cpu_ready) begin
        seen = 1'b1;
        chk("ready_cycle", 32'(c), 32'(exp_c));
        chk("ready_err", 32'(bus_err), 32'(exp_err));
        chk("ready_data", cpu_rd_data, exp_dat);
        drive_rsp(-1, 1'b0, 8'h00);
        break;
      end
      own = (hit && is_rd) ? slot : -1;
      drive_rsp(own, (c == 1 + lat), rdat);
    end
    if (!seen) chk("ready_seen", 32'd0, 32'd1);
    chk("wr_strobe_count", 32'(nwr), 32'(hit && wr));
    chk("rd_strobe_count", 32'(nrd), 32'(hit && is_rd));
    // Request still held through DONE; it must not be re-accepted there.
    @(negedge clk);
    chk("idle_after_done", 32'({cpu_ready, p_rd_en, p_wr_en}), 32'd0);
    chk("data_holds", cpu_rd_data, exp_dat);
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    drive_rsp(-1, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] a;
    int          mode, lat;
    rst = 1'b1;
    cpu_addr = '0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_wr_data = '0;
    p_rd_data = '0; p_rd_valid = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed accesses from the access scenarios
    txn(32'h0000_2000, 1'b0, 1'b1, 32'h1234_5680, 0, 8'h00);
    txn(32'h0000_2024, 1'b1, 1'b0, 32'h0, 1, 8'h5A);
    txn(32'h0000_20E0, 1'b1, 1'b0, 32'h0, 1, 8'h33);
    txn(32'h0000_3000, 1'b0, 1'b1, 32'h0000_00AA, 0, 8'h00);
    txn(32'h0000_2040, 1'b1, 1'b0, 32'h0, NEVER, 8'h00);
    txn(32'h0000_2008, 1'b1, 1'b1, 32'h0000_0011, 1, 8'h99);
    txn(32'h0000_2061, 1'b1, 1'b0, 32'h0, TO, 8'hC3);
    txn(32'h0000_2002, 1'b1, 1'b0, 32'h0, TO + 1, 8'h3C);
    txn(32'h0000_2043, 1'b1, 1'b0, 32'h0, 0, 8'hE7);

    // Reset in the middle of a read, then a late rd_valid
    @(negedge clk);
    cpu_addr = 32'h0000_2020; cpu_rd_en = 1'b1;
    drive_rsp(-1, 1'b0, 8'h00);
    p_rd_valid = '0;
    @(negedge clk);
    chk("abort_rd_en", 32'(p_rd_en), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0; cpu_rd_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      p_rd_valid = 4'b0010; p_rd_data = 32'h0000_7700;
      @(negedge clk);
      chk("abort_no_ready", 32'(cpu_ready), 32'd0);
    end
    p_rd_valid = '0;
    txn(32'h0000_2020, 1'b1, 1'b0, 32'h0, 1, 8'h42);

    // Randomized accesses
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[31:8] = BASE[31:8];
      mode = $urandom_range(0, 3);
      lat  = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, TO + 2);
      txn(a, (mode != 0), (mode == 0 || mode == 3), $urandom, lat, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
